// File: rtl/pipe_trace_buffer.sv
// Writeback-stage trace recorder: captures retiring instructions into a small
// on-chip ring buffer (optionally after a PC trigger), then drains oldest-first
// over a valid/ready port once capture has ended.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no session since reset; nothing recorded, nothing to drain
// WAIT_TRIG | armed, discarding retirements until wb_pc matches trig_pc
// CAPTURE   | recording every eligible retirement at wr_ptr
// DONE      | capture ended; buffer drains through rd_valid/rd_ready
module pipe_trace_buffer #(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 5,
    parameter int DEPTH   = 16,
    parameter int RW_ONLY = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic                       wb_regwrite,
    input  logic [DATA_W-1:0]          wb_pc,
    input  logic [RD_W-1:0]            wb_rd,
    input  logic [DATA_W-1:0]          wb_result,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       mode,
    input  logic                       trig_en,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [RD_W-1:0]            rd_rd,
    output logic [DATA_W-1:0]          rd_result,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_CAPTURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   trig_pc_q, trig_pc_d;
    logic                wr_en;
    logic                eligible;

    logic [DATA_W-1:0]   mem_pc     [DEPTH];
    logic [RD_W-1:0]     mem_rd     [DEPTH];
    logic [DATA_W-1:0]   mem_result [DEPTH];

    assign eligible = wb_valid && ((RW_ONLY == 0) || wb_regwrite);
    assign rd_valid = (state_q == S_DONE) && (count_q != '0);

    // Head fields are forced to zero whenever nothing is presented, so the
    // unreset storage never leaks onto the port (including right after reset).
    assign rd_pc     = rd_valid ? mem_pc[rd_ptr_q]     : '0;
    assign rd_rd     = rd_valid ? mem_rd[rd_ptr_q]     : '0;
    assign rd_result = rd_valid ? mem_result[rd_ptr_q] : '0;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign state    = state_q;

    // Next-state, pointer and write-enable decode; arm overrides everything.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mode_d     = mode_q;
        trig_pc_d  = trig_pc_q;
        wr_en      = 1'b0;
        if (arm) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            mode_d     = mode;
            trig_pc_d  = trig_pc;
            state_d    = trig_en ? S_WAIT_TRIG : S_CAPTURE;
        end else begin
            case (state_q)
                S_WAIT_TRIG: begin
                    if (eligible && (wb_pc == trig_pc_q)) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                        state_d  = S_CAPTURE;
                    end
                    if (stop) state_d = S_DONE;
                end
                S_CAPTURE: begin
                    if (eligible) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        // Only circular mode can reach a write with a full
                        // buffer; stop-when-full has already left CAPTURE.
                        if (count_q == CW'(DEPTH)) begin
                            rd_ptr_d   = rd_ptr_q + AW'(1);
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                            if (!mode_q && (count_q == CW'(DEPTH - 1)))
                                state_d = S_DONE;
                        end
                    end
                    if (stop) state_d = S_DONE;
                end
                S_DONE: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control registers; async reset abandons any session immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mode_q     <= 1'b0;
            trig_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
            trig_pc_q  <= trig_pc_d;
        end
    end

    // Trace storage write port; intentionally unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]     <= wb_pc;
            mem_rd[wr_ptr_q]     <= wb_rd;
            mem_result[wr_ptr_q] <= wb_result;
        end
    end

endmodule
